// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes used by every pipeline stage
// and the state encoding of the data-memory request controller.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mreq_state_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// Y86-64 memory-stage initiator: decodes one operation per start pulse and runs
// a req/ack handshake with timeout toward a variable-latency data memory.
module mem_req_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        mem_err,
  output logic        mreq,
  output logic        mwe,
  output logic [63:0] maddr,
  output logic [63:0] mwdata,
  input  logic        mack,
  input  logic [63:0] mrdata
);

  localparam logic [63:0] ADDR_LIMIT_W = 64'(ADDR_LIMIT);
  // Count value reached after TIMEOUT-1 unacked cycles; the next unacked cycle aborts.
  localparam logic [4:0]  TMO_LAST     = 5'(TIMEOUT - 1);

  mreq_state_t state_r;
  logic [4:0]  tmo_cnt_r;

  logic        is_mem_s;
  logic        is_wr_s;
  logic [63:0] op_addr_s;
  logic [63:0] op_wdata_s;
  logic        addr_bad_s;

  // Decode icode into direction, address and write data, then range-check the address.
  always_comb begin
    is_mem_s   = 1'b0;
    is_wr_s    = 1'b0;
    op_addr_s  = 64'd0;
    op_wdata_s = 64'd0;
    case (icode)
      IRMMOVQ: begin
        is_mem_s   = 1'b1;
        is_wr_s    = 1'b1;
        op_addr_s  = valE;
        op_wdata_s = valA;
      end
      IMRMOVQ: begin
        is_mem_s  = 1'b1;
        op_addr_s = valE;
      end
      ICALL: begin
        is_mem_s   = 1'b1;
        is_wr_s    = 1'b1;
        op_addr_s  = valE;
        op_wdata_s = valP;
      end
      IRET: begin
        is_mem_s  = 1'b1;
        op_addr_s = valA;
      end
      IPUSHQ: begin
        is_mem_s   = 1'b1;
        is_wr_s    = 1'b1;
        op_addr_s  = valE;
        op_wdata_s = valA;
      end
      IPOPQ: begin
        is_mem_s  = 1'b1;
        op_addr_s = valA;
      end
      default: begin
        is_mem_s = 1'b0;
      end
    endcase
    if (is_mem_s) begin
      addr_bad_s = (op_addr_s >= ADDR_LIMIT_W);
    end else begin
      addr_bad_s = 1'b0;
    end
  end

  // Handshake FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      tmo_cnt_r <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valM      <= 64'd0;
      mem_err   <= 1'b0;
      mreq      <= 1'b0;
      mwe       <= 1'b0;
      maddr     <= 64'd0;
      mwdata    <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (is_mem_s && !addr_bad_s) begin
              state_r   <= REQ;
              tmo_cnt_r <= 5'd0;
              mreq      <= 1'b1;
              mwe       <= is_wr_s;
              maddr     <= op_addr_s;
              mwdata    <= op_wdata_s;
            end else begin
              // Non-memory op completes cleanly; a bad address completes with an error.
              state_r <= DONE;
              done    <= 1'b1;
              mem_err <= is_mem_s;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        REQ: begin
          if (mack) begin
            state_r <= DONE;
            mreq    <= 1'b0;
            done    <= 1'b1;
            mem_err <= 1'b0;
            valM    <= mwe ? mwdata : mrdata;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r <= DONE;
            mreq    <= 1'b0;
            done    <= 1'b1;
            mem_err <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 5'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          mreq    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: table of single operations with a simple
// responder, plus hand sequences for busy-start, back-to-back and async reset.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        busy, done, mem_err, mreq, mwe;
  logic [63:0] valM, maddr, mwdata;
  logic        mack;
  logic [63:0] mrdata;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] val_a;
    logic [63:0] val_e;
    logic [63:0] val_p;
    int          ack_n;      // mack in this mreq cycle (1-based); 0 = never
    logic [63:0] rdata;
    logic        exp_req;
    logic        exp_mwe;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [63:0] exp_valm;
    logic        exp_err;
    int          exp_lat;    // cycles from start edge to the done cycle
    int          exp_reqcyc;
  } vec_t;

  vec_t vecs[10];
  vec_t vr;

  mem_req_ctrl #(.ADDR_LIMIT(1024), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .mem_err(mem_err),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mack(mack), .mrdata(mrdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic run_op(input vec_t v, input int id);
    int  reqcyc;
    int  lat;
    bit  first;
    @(negedge clk);
    mack  = 1'b0;
    start = 1'b1;
    icode = v.icode;
    valA  = v.val_a;
    valE  = v.val_e;
    valP  = v.val_p;
    @(negedge clk);
    start  = 1'b0;
    check($sformatf("v%0d busy_after_start", id), busy, 64'd1);
    reqcyc = 0;
    lat    = 0;
    first  = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      mack = 1'b0;
      if (done) begin
        lat = c;
      end else if (mreq) begin
        reqcyc++;
        if (first) begin
          first = 1'b0;
          check($sformatf("v%0d maddr", id), maddr, v.exp_addr);
          check($sformatf("v%0d mwe", id), mwe, 64'(v.exp_mwe));
          if (v.exp_mwe) check($sformatf("v%0d mwdata", id), mwdata, v.exp_wdata);
        end
        if (reqcyc == v.ack_n) begin
          mack   = 1'b1;
          mrdata = v.rdata;
        end
      end
      if (lat == 0) @(negedge clk);
    end
    mack = 1'b0;
    check($sformatf("v%0d latency", id), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d req_cycles", id), 64'(reqcyc), 64'(v.exp_reqcyc));
    check($sformatf("v%0d valM", id), valM, v.exp_valm);
    check($sformatf("v%0d mem_err", id), mem_err, 64'(v.exp_err));
    check($sformatf("v%0d mreq_at_done", id), mreq, 64'd0);
    check($sformatf("v%0d busy_at_done", id), busy, 64'd1);
    @(negedge clk);
    check($sformatf("v%0d done_drop", id), done, 64'd0);
    check($sformatf("v%0d busy_drop", id), busy, 64'd0);
  endtask

  initial begin
    int ndone;
    int nburst;
    bit prev_mreq;

    //           icode  valA         valE                     valP       ack rdata        req mwe addr       wdata      valM       err lat rc
    vecs[0] = '{4'h5, 64'h0,      64'h20,                  64'h0,     3,  64'hDEAD, 1'b1, 1'b0, 64'h20,  64'h0,    64'hDEAD, 1'b0, 4,  3};
    vecs[1] = '{4'h8, 64'h777,    64'h3F8,                 64'h115,   1,  64'h0,    1'b1, 1'b1, 64'h3F8, 64'h115,  64'h115,  1'b0, 2,  1};
    vecs[2] = '{4'hA, 64'h55,     64'd1024,                64'h0,     1,  64'h0,    1'b0, 1'b0, 64'h0,   64'h0,    64'h115,  1'b1, 1,  0};
    vecs[3] = '{4'hB, 64'h10,     64'h0,                   64'h0,     0,  64'h0,    1'b1, 1'b0, 64'h10,  64'h0,    64'h115,  1'b1, 17, 16};
    vecs[4] = '{4'h1, 64'h0,      64'h0,                   64'h0,     1,  64'h0,    1'b0, 1'b0, 64'h0,   64'h0,    64'h115,  1'b0, 1,  0};
    vecs[5] = '{4'h4, 64'hCAFE,   64'h3FF,                 64'h0,     2,  64'h0,    1'b1, 1'b1, 64'h3FF, 64'hCAFE, 64'hCAFE, 1'b0, 3,  2};
    vecs[6] = '{4'h9, 64'h8,      64'h0,                   64'h0,     16, 64'h1234, 1'b1, 1'b0, 64'h8,   64'h0,    64'h1234, 1'b0, 17, 16};
    vecs[7] = '{4'h5, 64'h0,      64'hFFFF_FFFF_FFFF_FFF8, 64'h0,     1,  64'h0,    1'b0, 1'b0, 64'h0,   64'h0,    64'h1234, 1'b1, 1,  0};
    vecs[8] = '{4'hA, 64'hBEEF,   64'h100,                 64'h0,     1,  64'h0,    1'b1, 1'b1, 64'h100, 64'hBEEF, 64'hBEEF, 1'b0, 2,  1};
    vecs[9] = '{4'h0, 64'h0,      64'h0,                   64'h0,     1,  64'h0,    1'b0, 1'b0, 64'h0,   64'h0,    64'hBEEF, 1'b0, 1,  0};

    rst = 1'b1; start = 1'b0; icode = 4'h0; mack = 1'b0; mrdata = 64'h0;
    valA = 64'h0; valE = 64'h0; valP = 64'h0;
    repeat (2) @(negedge clk);
    check("rst mreq", mreq, 64'd0);
    check("rst mwe", mwe, 64'd0);
    check("rst maddr", maddr, 64'd0);
    check("rst mwdata", mwdata, 64'd0);
    check("rst valM", valM, 64'd0);
    check("rst mem_err", mem_err, 64'd0);
    check("rst done", done, 64'd0);
    check("rst busy", busy, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i], i);

    // mack while idle must not disturb anything
    @(negedge clk); mack = 1'b1; mrdata = 64'h9999;
    @(negedge clk); mack = 1'b0;
    check("idle_mack done", done, 64'd0);
    check("idle_mack valM", valM, 64'hBEEF);
    check("idle_mack busy", busy, 64'd0);

    // second start while busy is ignored
    @(negedge clk); start = 1'b1; icode = 4'h5; valE = 64'h30;
    @(negedge clk); start = 1'b0;
    ndone = 0; nburst = 0; prev_mreq = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      mack  = 1'b0;
      start = 1'b0;
      if (mreq && !prev_mreq) nburst++;
      prev_mreq = mreq;
      if (done) ndone++;
      if (c == 2) begin start = 1'b1; icode = 4'h1; end
      if (c == 3 && mreq) begin mack = 1'b1; mrdata = 64'h4242; end
      @(negedge clk);
    end
    check("busy_start done_count", 64'(ndone), 64'd1);
    check("busy_start mreq_bursts", 64'(nburst), 64'd1);
    check("busy_start valM", valM, 64'h4242);

    // back-to-back: start seen while leaving DONE is ignored, next edge accepted
    @(negedge clk); start = 1'b1; icode = 4'h1;
    @(negedge clk);
    check("b2b first_done", done, 64'd1);
    @(negedge clk);
    check("b2b ignored_done", done, 64'd0);
    check("b2b ignored_busy", busy, 64'd0);
    @(negedge clk); start = 1'b0;
    check("b2b second_done", done, 64'd1);
    @(negedge clk);
    check("b2b second_drop", done, 64'd0);

    // asynchronous reset in the middle of a request
    @(negedge clk); start = 1'b1; icode = 4'hB; valA = 64'h40;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("arst mreq_before", mreq, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst mreq", mreq, 64'd0);
    check("arst busy", busy, 64'd0);
    check("arst done", done, 64'd0);
    @(negedge clk); rst = 1'b0;
    vr = '{4'h5, 64'h0, 64'h18, 64'h0, 2, 64'h5A5A, 1'b1, 1'b0, 64'h18, 64'h0, 64'h5A5A, 1'b0, 3, 2};
    run_op(vr, 99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
